// File: rtl/mem_access_arb_pkg.sv
// Shared constants, FSM state encoding and requester IDs for the scratch
// memory arbiter.
package mem_access_arb_pkg;

    localparam int ADDR_W    = 16;
    localparam int MEM_DEPTH = 1201;
    localparam int VEC_LEN   = 20;

    // Highest legal base address per requester, one bit wider than the bus
    // so the compare can never wrap.
    localparam logic [ADDR_W:0] LD_ADDR_MAX = (ADDR_W+1)'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0] CP_ADDR_MAX = (ADDR_W+1)'(MEM_DEPTH - VEC_LEN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        LD = 1'b0,
        CP = 1'b1
    } req_id_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input logic [ADDR_W:0]   max_addr);
        return ({1'b0, addr} <= max_addr);
    endfunction

endpackage

// File: rtl/mem_access_arb_if.sv
// Requester handshakes plus the memory control bus driven by the arbiter.
interface mem_access_arb_if;
    import mem_access_arb_pkg::*;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_gnt;

    logic              cp_req;
    logic              cp_rw;
    logic [ADDR_W-1:0] cp_addr;
    logic              cp_gnt;
    logic              cp_rvalid;

    logic              err;
    logic              busy;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_abus;
    logic              mem_insign;
    logic [7:0]        mem_indata;

    // Arbiter side.
    modport slave (
        input  ld_req, ld_addr, ld_data, cp_req, cp_rw, cp_addr,
        output ld_gnt, cp_gnt, cp_rvalid, err, busy,
               mem_en, mem_rw, mem_abus, mem_insign, mem_indata
    );

    // Requester / memory side.
    modport master (
        output ld_req, ld_addr, ld_data, cp_req, cp_rw, cp_addr,
        input  ld_gnt, cp_gnt, cp_rvalid, err, busy,
               mem_en, mem_rw, mem_abus, mem_insign, mem_indata
    );

endinterface

// File: rtl/mem_access_arb_rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not win last
// time is chosen; the last winner is remembered only when the pick is taken.
module mem_access_arb_rr_arb2
    import mem_access_arb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    i_req_ld,
    input  logic    i_req_cp,
    input  logic    i_take,
    output logic    o_valid,
    output req_id_t o_id
);

    req_id_t r_last;

    // Pick a winner from the current requests and the last winner.
    always_comb begin
        o_valid = i_req_ld | i_req_cp;
        o_id    = LD;
        if (i_req_ld && i_req_cp) begin
            o_id = (r_last == LD) ? CP : LD;
        end else if (i_req_cp) begin
            o_id = CP;
        end
    end

    // Remember the last winner; CP after reset so the loader wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= CP;
        end else if (i_take) begin
            r_last <= o_id;
        end
    end

endmodule

// File: rtl/mem_access_arb.sv
// Shares the scratch memory between the pixel loader (byte writes) and the
// texture compute engine (20-byte vector reads/writes). Every output is a
// register loaded from the decision made in the current state.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | sample requests, grant one, range-check it
//   ISSUE   | mem_en high; memory samples at the edge ending this state
//   RD_WAIT | read data settling; cp_rvalid is raised on exit
module mem_access_arb
    import mem_access_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mem_access_arb_if.slave   bus
);

    state_t            r_state;
    state_t            w_next_state;

    logic              r_ld_gnt, r_cp_gnt, r_cp_rvalid, r_err, r_busy;
    logic              r_mem_en, r_mem_rw, r_mem_insign;
    logic [ADDR_W-1:0] r_mem_abus;
    logic [7:0]        r_mem_indata;

    logic              w_ld_gnt, w_cp_gnt, w_cp_rvalid, w_err;
    logic              w_mem_en, w_mem_rw, w_mem_insign;
    logic [ADDR_W-1:0] w_mem_abus;
    logic [7:0]        w_mem_indata;

    logic              w_arb_valid;
    req_id_t           w_arb_id;
    logic              w_take;

    mem_access_arb_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .i_req_ld (bus.ld_req),
        .i_req_cp (bus.cp_req),
        .i_take   (w_take),
        .o_valid  (w_arb_valid),
        .o_id     (w_arb_id)
    );

    // Next state and next output values; memory fields hold unless a legal
    // access is being launched.
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_ld_gnt     = 1'b0;
        w_cp_gnt     = 1'b0;
        w_cp_rvalid  = 1'b0;
        w_err        = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_rw     = r_mem_rw;
        w_mem_insign = r_mem_insign;
        w_mem_abus   = r_mem_abus;
        w_mem_indata = r_mem_indata;

        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_take = 1'b1;
                    if (w_arb_id == LD) begin
                        w_ld_gnt = 1'b1;
                        if (addr_in_range(bus.ld_addr, LD_ADDR_MAX)) begin
                            w_mem_en     = 1'b1;
                            w_mem_rw     = 1'b0;
                            w_mem_insign = 1'b1;
                            w_mem_abus   = bus.ld_addr;
                            w_mem_indata = bus.ld_data;
                            w_next_state = ISSUE;
                        end else begin
                            w_err = 1'b1;
                        end
                    end else begin
                        w_cp_gnt = 1'b1;
                        if (addr_in_range(bus.cp_addr, CP_ADDR_MAX)) begin
                            w_mem_en     = 1'b1;
                            w_mem_rw     = bus.cp_rw;
                            w_mem_insign = 1'b0;
                            w_mem_abus   = bus.cp_addr;
                            w_next_state = ISSUE;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                end
            end
            // Only compute reads ever launch with mem_rw high.
            ISSUE: begin
                w_next_state = r_mem_rw ? RD_WAIT : IDLE;
            end
            RD_WAIT: begin
                w_cp_rvalid  = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ld_gnt     <= 1'b0;
            r_cp_gnt     <= 1'b0;
            r_cp_rvalid  <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_rw     <= 1'b0;
            r_mem_insign <= 1'b0;
            r_mem_abus   <= '0;
            r_mem_indata <= '0;
        end else begin
            r_state      <= w_next_state;
            r_ld_gnt     <= w_ld_gnt;
            r_cp_gnt     <= w_cp_gnt;
            r_cp_rvalid  <= w_cp_rvalid;
            r_err        <= w_err;
            r_busy       <= (w_next_state != IDLE);
            r_mem_en     <= w_mem_en;
            r_mem_rw     <= w_mem_rw;
            r_mem_insign <= w_mem_insign;
            r_mem_abus   <= w_mem_abus;
            r_mem_indata <= w_mem_indata;
        end
    end

    assign bus.ld_gnt     = r_ld_gnt;
    assign bus.cp_gnt     = r_cp_gnt;
    assign bus.cp_rvalid  = r_cp_rvalid;
    assign bus.err        = r_err;
    assign bus.busy       = r_busy;
    assign bus.mem_en     = r_mem_en;
    assign bus.mem_rw     = r_mem_rw;
    assign bus.mem_abus   = r_mem_abus;
    assign bus.mem_insign = r_mem_insign;
    assign bus.mem_indata = r_mem_indata;

endmodule
